// File: rtl/ws2812_rx.sv
`timescale 1ns/1ps
// WS2812 single-wire receiver: recovers 24-bit GRB pixels from high-pulse
// widths on din and reports the end of each frame at the latch gap.
module ws2812_rx #(
  parameter int SYSTEM_CLOCK     = 50000000,
  parameter int NUM_LEDS         = 16,
  parameter int BIT_THRESHOLD_NS = 600,
  parameter int MAX_HIGH_NS      = 5000,
  parameter int LATCH_US         = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        din,
  output logic                        pixel_valid,
  output logic [23:0]                 pixel_data,
  output logic [$clog2(NUM_LEDS)-1:0] pixel_index,
  output logic                        frame_done,
  output logic [$clog2(NUM_LEDS):0]   frame_count,
  output logic                        overflow,
  output logic                        error,
  output logic                        in_frame
);

  localparam int ONE_CYC   = int'((64'(BIT_THRESHOLD_NS) * 64'(SYSTEM_CLOCK)) / 64'd1000000000);
  localparam int MAXH_CYC  = int'((64'(MAX_HIGH_NS) * 64'(SYSTEM_CLOCK)) / 64'd1000000000);
  localparam int LATCH_CYC = int'((64'(LATCH_US) * 64'(SYSTEM_CLOCK)) / 64'd1000000);
  localparam int CNT_MAX   = (LATCH_CYC > MAXH_CYC) ? LATCH_CYC : MAXH_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int IDX_W     = $clog2(NUM_LEDS);
  localparam int PIX_W     = IDX_W + 1;

  typedef enum logic [1:0] {RESYNC, IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic             din_meta, din_sync, din_prev;
  logic             rise, fall, bit_val;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic [4:0]       bit_cnt;
  logic [22:0]      shreg;
  logic [23:0]      word;
  logic [PIX_W-1:0] pix_cnt;
  logic             ovf_pend;

  assign rise    = din_sync & ~din_prev;
  assign fall    = ~din_sync & din_prev;
  assign bit_val = (high_cnt >= CNT_W'(ONE_CYC));
  assign word    = {shreg, bit_val};

  always_ff @(posedge clk) begin
    if (reset) begin
      din_meta    <= 1'b0;
      din_sync    <= 1'b0;
      din_prev    <= 1'b0;
      state       <= RESYNC;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      pix_cnt     <= '0;
      ovf_pend    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      error       <= 1'b0;
      in_frame    <= 1'b0;
    end else begin
      din_meta    <= din;
      din_sync    <= din_meta;
      din_prev    <= din_sync;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      case (state)
        // Decode nothing until a full latch gap proves we are between frames.
        RESYNC: begin
          if (din_sync) begin
            low_cnt <= '0;
          end else if (low_cnt >= CNT_W'(LATCH_CYC - 1)) begin
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= CNT_W'(1);
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            in_frame <= 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            shreg   <= word[22:0];
            low_cnt <= '0;
            state   <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_cnt < PIX_W'(NUM_LEDS)) begin
                pixel_valid <= 1'b1;
                pixel_data  <= word;
                pixel_index <= pix_cnt[IDX_W-1:0];
                pix_cnt     <= pix_cnt + 1'b1;
              end else begin
                ovf_pend <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (high_cnt >= CNT_W'(MAXH_CYC - 1)) begin
            // Line stuck high: abandon the frame without a frame_done.
            error    <= 1'b1;
            in_frame <= 1'b0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            low_cnt  <= '0;
            state    <= RESYNC;
          end else begin
            high_cnt <= high_cnt + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= CNT_W'(1);
          end else if (low_cnt >= CNT_W'(LATCH_CYC - 1)) begin
            error       <= (bit_cnt != 5'd0);
            frame_done  <= 1'b1;
            frame_count <= pix_cnt;
            overflow    <= ovf_pend;
            ovf_pend    <= 1'b0;
            in_frame    <= 1'b0;
            bit_cnt     <= '0;
            state       <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
        default: state <= RESYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
`timescale 1ns/1ps
// Bench for ws2812_rx: directed and random pulse trains scored against a
// pulse-level model of the WS2812 decoding rules.
module tb_ws2812_rx;
  localparam int NUM_LEDS = 16;
  localparam int IDX_W    = $clog2(NUM_LEDS);
  localparam int ONE_CYC  = 30;
  localparam int MAXH_CYC = 250;
  localparam int LATCH    = 2000;
  localparam int GAP      = 2100;
  localparam int LONG_GAP = 2500;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             din = 1'b0;
  logic             pixel_valid;
  logic [23:0]      pixel_data;
  logic [IDX_W-1:0] pixel_index;
  logic             frame_done;
  logic [IDX_W:0]   frame_count;
  logic             overflow, error, in_frame;

  ws2812_rx #(.SYSTEM_CLOCK(50000000), .NUM_LEDS(NUM_LEDS), .BIT_THRESHOLD_NS(600),
              .MAX_HIGH_NS(5000), .LATCH_US(40)) dut (
    .clk(clk), .reset(reset), .din(din),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow),
    .error(error), .in_frame(in_frame));

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pulse-level model state and expected-event queues.
  bit          m_aligned = 1'b0;
  bit          m_in_frame = 1'b0;
  int          m_bits = 0;
  logic [23:0] m_sh = '0;
  int          m_pix = 0;
  bit          m_ovf = 1'b0;
  int          fault_pend = 0;
  logic [23:0] q_pix_data[$];
  int          q_pix_idx[$];
  int          q_fc[$];
  bit          q_ovf[$];
  bit          q_err[$];
  int          hold_fc = 0;
  bit          hold_ovf = 1'b0;

  // Observations from the compare process.
  int          n_pix = 0, n_frames = 0, n_fault = 0;
  logic [23:0] last_pix = '0;
  int          last_idx = 0, last_fc = 0;
  bit          last_ovf = 1'b0, last_err = 1'b0;
  longint      err_time = 0, t_rise = 0;
  int          p0, f0, e0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_high(input int h);
    if (m_aligned) begin
      m_in_frame = 1'b1;
      if (h >= MAXH_CYC) begin
        fault_pend++;
        m_aligned  = 1'b0;
        m_in_frame = 1'b0;
        m_bits     = 0;
        m_ovf      = 1'b0;
      end else begin
        m_sh = {m_sh[22:0], (h >= ONE_CYC)};
        m_bits++;
        if (m_bits == 24) begin
          m_bits = 0;
          if (m_pix < NUM_LEDS) begin
            q_pix_data.push_back(m_sh);
            q_pix_idx.push_back(m_pix);
            m_pix++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic mdl_low(input int l);
    if (!m_aligned) begin
      if (l >= LATCH) m_aligned = 1'b1;
    end else if (m_in_frame && l >= LATCH) begin
      q_fc.push_back(m_pix);
      q_ovf.push_back(m_ovf);
      q_err.push_back(m_bits != 0);
      m_in_frame = 1'b0;
      m_pix = 0;
      m_bits = 0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input int n);
    @(negedge clk);
    din = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send(input int h, input int l);
    mdl_high(h);
    drive(1'b1, h);
    mdl_low(l);
    drive(1'b0, l);
  endtask

  task automatic gap(input int l);
    mdl_low(l);
    drive(1'b0, l);
  endtask

  task automatic send_bits(input logic [23:0] w, input int first, input int last,
                           input int h0, input int h1, input int period);
    for (int i = first; i >= last; i--) send(w[i] ? h1 : h0, period - (w[i] ? h1 : h0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    m_aligned = 1'b0; m_in_frame = 1'b0; m_bits = 0; m_pix = 0; m_ovf = 1'b0;
    hold_fc = 0; hold_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pixel_valid", 32'(pixel_valid), 0);
    check("rst_pixel_data", 32'(pixel_data), 0);
    check("rst_pixel_index", 32'(pixel_index), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_error", 32'(error), 0);
    check("rst_in_frame", 32'(in_frame), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Compare process: score every strobe against the model's queues.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pixel_valid === 1'b1 && frame_done === 1'b1) begin
        checks++; errors++;
        $display("FAIL strobe_overlap: pixel_valid and frame_done both 1, required not both");
      end
      if (pixel_valid === 1'b1) begin
        n_pix++; last_pix = pixel_data; last_idx = int'(pixel_index);
        if (q_pix_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel: data %06h index %0d, required no strobe", pixel_data, pixel_index);
        end else begin
          check("pixel_data", 32'(pixel_data), 32'(q_pix_data.pop_front()));
          check("pixel_index", 32'(pixel_index), 32'(q_pix_idx.pop_front()));
        end
      end
      if (frame_done === 1'b1) begin
        n_frames++; last_fc = int'(frame_count); last_ovf = overflow; last_err = error;
        if (q_fc.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_done: count %0d, required no strobe", frame_count);
        end else begin
          hold_fc = q_fc.pop_front();
          hold_ovf = q_ovf.pop_front();
          check("frame_count", 32'(frame_count), 32'(hold_fc));
          check("overflow", 32'(overflow), 32'(hold_ovf));
          check("partial_error", 32'(error), 32'(q_err.pop_front()));
        end
      end else begin
        check("frame_count_hold", 32'(frame_count), 32'(hold_fc));
        check("overflow_hold", 32'(overflow), 32'(hold_ovf));
        if (error === 1'b1) begin
          n_fault++; err_time = $time; checks++;
          if (fault_pend == 0) begin
            errors++;
            $display("FAIL unexpected_error: error=1, required 0 at %0t", $time);
          end else begin
            fault_pend--;
          end
        end
      end
    end
  end

  initial begin
    logic [23:0] w;
    int npx, nb;

    repeat (3) @(negedge clk);
    check("reset_pixel_valid", 32'(pixel_valid), 0);
    check("reset_frame_count", 32'(frame_count), 0);
    check("reset_in_frame", 32'(in_frame), 0);
    reset = 1'b0;
    gap(GAP);

    // Single pixel with nominal WS2812 timing.
    p0 = n_pix; f0 = n_frames;
    send_bits(24'hA53C0F, 23, 0, 20, 40, 62);
    check("t1_in_frame", 32'(in_frame), 1);
    gap(LONG_GAP);
    check("t1_npix", 32'(n_pix - p0), 1);
    check("t1_data", 32'(last_pix), 32'h00A53C0F);
    check("t1_index", 32'(last_idx), 0);
    check("t1_nframes", 32'(n_frames - f0), 1);
    check("t1_fc", 32'(last_fc), 1);
    check("t1_ovf", 32'(last_ovf), 0);
    check("t1_err", 32'(last_err), 0);
    check("t1_in_frame_end", 32'(in_frame), 0);

    // Threshold: 30 cycles -> 1, 29 cycles -> 0.
    p0 = n_pix;
    for (int i = 0; i < 24; i++) send((i % 2 == 0) ? 30 : 29, 31);
    gap(GAP);
    check("t2_npix", 32'(n_pix - p0), 1);
    check("t2_data", 32'(last_pix), 32'h00AAAAAA);

    // 17 pixels: one more than accepted.
    p0 = n_pix;
    for (int k = 0; k < 17; k++) send_bits(24'(k * 24'h010101), 23, 0, 12, 36, 48);
    gap(GAP);
    check("t3_npix", 32'(n_pix - p0), 16);
    check("t3_last_index", 32'(last_idx), 15);
    check("t3_last_data", 32'(last_pix), 32'h000F0F0F);
    check("t3_fc", 32'(last_fc), 16);
    check("t3_ovf", 32'(last_ovf), 1);
    send_bits(24'h123456, 23, 0, 20, 40, 62);
    gap(GAP);
    check("t3b_fc", 32'(last_fc), 1);
    check("t3b_ovf", 32'(last_ovf), 0);

    // Partial pixel at latch.
    p0 = n_pix; f0 = n_frames;
    send_bits(24'hA53C0F, 23, 12, 20, 40, 62);
    gap(LONG_GAP);
    check("t4_npix", 32'(n_pix - p0), 0);
    check("t4_nframes", 32'(n_frames - f0), 1);
    check("t4_err", 32'(last_err), 1);
    check("t4_fc", 32'(last_fc), 0);

    // Stuck-high fault mid-pixel, then realignment.
    p0 = n_pix; f0 = n_frames; e0 = n_fault;
    send_bits(24'hFFFFFF, 23, 14, 20, 40, 62);
    mdl_high(300);
    @(negedge clk);
    din = 1'b1;
    t_rise = $time;
    repeat (299) @(negedge clk);
    gap(500);
    check("t5_fault_seen", 32'(n_fault - e0), 1);
    check("t5_fault_delay_ok", 32'((err_time - t_rise) >= 5000 && (err_time - t_rise) <= 5080), 1);
    check("t5_in_frame", 32'(in_frame), 0);
    send_bits(24'h777777, 23, 0, 20, 40, 62);
    gap(GAP);
    check("t5_ignored_npix", 32'(n_pix - p0), 0);
    check("t5_ignored_frames", 32'(n_frames - f0), 0);
    send_bits(24'h5A5A5A, 23, 0, 20, 40, 62);
    gap(GAP);
    check("t5_npix", 32'(n_pix - p0), 1);
    check("t5_data", 32'(last_pix), 32'h005A5A5A);
    check("t5_nframes", 32'(n_frames - f0), 1);

    // Reset mid-pixel.
    send_bits(24'h3C3C3C, 23, 14, 20, 40, 62);
    pulse_reset();
    p0 = n_pix; f0 = n_frames;
    send_bits(24'h3C3C3C, 13, 0, 20, 40, 62);
    gap(GAP);
    check("t6_npix", 32'(n_pix - p0), 0);
    check("t6_nframes", 32'(n_frames - f0), 0);
    send_bits(24'hC0FFEE, 23, 0, 20, 40, 62);
    gap(GAP);
    check("t6_data", 32'(last_pix), 32'h00C0FFEE);
    check("t6_fc", 32'(last_fc), 1);

    // Random frames with jittered pulse widths, some with a partial pixel.
    for (int f = 0; f < 3; f++) begin
      npx = int'($urandom_range(1, 2));
      for (int p = 0; p < npx; p++) begin
        w = 24'($urandom);
        for (int i = 23; i >= 0; i--)
          send(w[i] ? int'($urandom_range(30, 70)) : int'($urandom_range(6, 29)),
               int'($urandom_range(6, 40)));
      end
      if ($urandom_range(0, 1) == 0) begin
        nb = int'($urandom_range(1, 23));
        for (int i = 0; i < nb; i++)
          send(int'($urandom_range(6, 70)), int'($urandom_range(6, 40)));
      end
      gap(GAP);
    end

    repeat (20) @(negedge clk);
    check("left_pixels", 32'(q_pix_data.size()), 0);
    check("left_frames", 32'(q_fc.size()), 0);
    check("left_faults", 32'(fault_pend), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
